// File: rtl/ps2_receptor_pkg.sv
// Shared PS/2 framing constants, FSM state encoding and frame validation helper.
package ps2_receptor_pkg;

    localparam int PS2_FRAME_BITS = 11;
    localparam int PS2_DATA_BITS  = 8;

    // Scan-code prefixes, shared with the downstream break/extended detector.
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DPS  = 2'b01,
        ST_LOAD = 2'b10
    } ps2_state_t;

    // b holds {stop, parity, data[7:0]}; odd parity means data^parity is 1.
    function automatic logic frame_ok(input logic [PS2_FRAME_BITS-2:0] b);
        return (^b[PS2_DATA_BITS:0]) && b[PS2_DATA_BITS+1];
    endfunction

endpackage

// File: rtl/ps2_filtro_flanco.sv
// PS/2 line conditioning: two-FF synchronisers on clock and data, a
// FILTER_LEN-sample glitch filter on the clock and a falling-edge tick.
// Also used by the mouse path.
module ps2_filtro_flanco
    import ps2_receptor_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2d_s,
    output logic fall_tick
);

    logic [1:0]            r_c_sync;
    logic [1:0]            r_d_sync;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_filt;
    logic                  r_filt_d;

    // Synchronise both lines, shift the clock history and update the filtered level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_hist   <= '1;
            r_filt   <= 1'b1;
            r_filt_d <= 1'b1;
        end else begin
            r_c_sync <= {r_c_sync[0], ps2c};
            r_d_sync <= {r_d_sync[0], ps2d};
            r_hist   <= {r_hist[FILTER_LEN-2:0], r_c_sync[1]};
            // A level change needs a full window of agreeing samples.
            if (&r_hist) begin
                r_filt <= 1'b1;
            end else if (~|r_hist) begin
                r_filt <= 1'b0;
            end
            r_filt_d <= r_filt;
        end
    end

    assign ps2d_s    = r_d_sync[1];
    assign fall_tick = r_filt_d & ~r_filt;

endmodule

// File: rtl/ps2_receptor.sv
// PS/2 frame receiver: deframes start/8 data/odd parity/stop on filtered
// clock falling edges, validates the frame and presents the scan code.
module ps2_receptor
    import ps2_receptor_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic [7:0] datos,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       busy
);

    localparam int                 WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]    WD_LAST = WD_W'(TIMEOUT - 1);
    localparam int                 B_W     = PS2_FRAME_BITS - 1;
    localparam logic [3:0]         N_FIRST = 4'(PS2_FRAME_BITS - 2);

    logic            w_ps2d_s;
    logic            w_fall_tick;
    logic [B_W-1:0]  w_b_next;

    ps2_state_t      r_state;
    logic [3:0]      r_n;
    logic [WD_W-1:0] r_wd;
    logic [B_W-1:0]  r_b;
    logic [7:0]      r_datos;
    logic            r_done;
    logic            r_err;
    logic            r_busy;

    ps2_filtro_flanco #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filtro (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .ps2d_s    (w_ps2d_s),
        .fall_tick (w_fall_tick)
    );

    // Bits arrive LSB first, so each new bit enters at the top and shifts down.
    assign w_b_next = {w_ps2d_s, r_b[B_W-1:1]};

    // Frame FSM with watchdog; the result pulses are registered so that they
    // are high exactly during the load cycle (or the cycle after a timeout).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_n     <= '0;
            r_wd    <= '0;
            r_b     <= '0;
            r_datos <= 8'h00;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_wd <= '0;
                    // rx_en only qualifies the start bit; a high data line is not a start.
                    if (w_fall_tick && rx_en && !w_ps2d_s) begin
                        r_state <= ST_DPS;
                        r_n     <= N_FIRST;
                        r_busy  <= 1'b1;
                    end
                end
                ST_DPS: begin
                    if (w_fall_tick) begin
                        r_b  <= w_b_next;
                        r_wd <= '0;
                        if (r_n == 4'd0) begin
                            // Stop bit just arrived: decide now so datos and the
                            // pulse appear together while in load.
                            r_state <= ST_LOAD;
                            if (frame_ok(w_b_next)) begin
                                r_datos <= w_b_next[7:0];
                                r_done  <= 1'b1;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end else begin
                            r_n <= r_n - 4'd1;
                        end
                    end else if (r_wd == WD_LAST) begin
                        // Line went quiet mid-frame: abandon it.
                        r_state <= ST_IDLE;
                        r_err   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_wd    <= '0;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign datos        = r_datos;
    assign rx_done_tick = r_done;
    assign frame_err    = r_err;
    assign busy         = r_busy;

endmodule
